branch_flush_ctrl: RTL and testbench

- Sits at the EX end of the ID/EX pipeline register and closes the loop back toward IF/ID.
- Consumes the branch/jump resolution produced in EX and generates the `IDEX_discard` and `IFID_discard` flush strobes that the pipeline registers sample.
- Issues a PC redirect to the fetch unit with a valid/ready handshake, and holds the flush until fetch has accepted the redirect plus a configurable shadow window.
- Static predict-not-taken: every taken branch or jump is a redirect.

---
 rtl/branch_flush_ctrl_pkg.sv | 13 +
 rtl/branch_flush_ctrl_shadow.sv | 27 ++
 rtl/branch_flush_ctrl.sv | 99 +++++++++
 tb/tb_branch_flush_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_flush_ctrl_pkg.sv
// Shared types and constants for the EX-stage branch flush controller.
package branch_flush_ctrl_pkg;

    typedef enum logic [1:0] {
        FlushIdle    = 2'b00,
        FlushWaitAck = 2'b01,
        FlushShadow  = 2'b10
    } flush_state_e;

    localparam int unsigned ShadowCntW      = 4;
    localparam int unsigned MaxShadowCycles = 15;

endpackage

// File: rtl/branch_flush_ctrl_shadow.sv
// Loadable down counter that times the post-acceptance IF/ID discard window.
module branch_flush_ctrl_shadow #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             last
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    // Treat 0 as last too so a stray zero can never trap the FSM in SHADOW.
    assign last = (cnt <= CNT_W'(1));

endmodule

// File: rtl/branch_flush_ctrl.sv
// Turns EX branch resolution into pipeline flush strobes and a handshaked PC
// redirect toward fetch (static predict-not-taken).
module branch_flush_ctrl
    import branch_flush_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W        = 32,
    parameter int unsigned SHADOW_CYCLES = 1,
    parameter int unsigned CNT_W         = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_branch_valid,
    input  logic              ex_branch_taken,
    input  logic [ADDR_W-1:0] ex_branch_target,
    input  logic              stall_i,
    input  logic              if_redirect_ready,
    output logic              if_redirect_valid,
    output logic [ADDR_W-1:0] if_redirect_pc,
    output logic              IFID_discard_o,
    output logic              IDEX_discard_o,
    output logic              flush_busy,
    output logic [CNT_W-1:0]  taken_count
);

    localparam logic [ShadowCntW-1:0] ShadowLoad = ShadowCntW'(SHADOW_CYCLES);
    localparam bit                    HasShadow  = (SHADOW_CYCLES != 0);

    flush_state_e          state;
    logic                  take;
    logic                  accept;
    logic                  shadow_load;
    logic                  shadow_dec;
    logic                  shadow_last;
    logic [ShadowCntW-1:0] shadow_cnt;
    logic [ADDR_W-1:0]     target_aligned;

    // Gated by rst so the strobes stay low throughout reset.
    assign take = rst && (state == FlushIdle) && ex_branch_valid && ex_branch_taken
                  && !stall_i;

    assign accept         = (state == FlushWaitAck) && if_redirect_ready;
    assign target_aligned = ex_branch_target & ~ADDR_W'(1);

    assign shadow_load = accept && HasShadow;
    assign shadow_dec  = (state == FlushShadow);

    // Discards depend only on state and EX inputs; ready never reaches them.
    assign IFID_discard_o = take || (state != FlushIdle);
    assign IDEX_discard_o = take || (state != FlushIdle);
    assign flush_busy     = (state != FlushIdle);

    branch_flush_ctrl_shadow #(
        .CNT_W (ShadowCntW)
    ) u_shadow (
        .clk      (clk),
        .rst      (rst),
        .load     (shadow_load),
        .load_val (ShadowLoad),
        .dec      (shadow_dec),
        .cnt      (shadow_cnt),
        .last     (shadow_last)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state             <= FlushIdle;
            if_redirect_valid <= 1'b0;
            if_redirect_pc    <= '0;
            taken_count       <= '0;
        end else begin
            unique case (state)
                FlushIdle: begin
                    if (take) begin
                        if_redirect_pc    <= target_aligned;
                        if_redirect_valid <= 1'b1;
                        taken_count       <= taken_count + CNT_W'(1);
                        state             <= FlushWaitAck;
                    end
                end
                FlushWaitAck: begin
                    if (accept) begin
                        if_redirect_valid <= 1'b0;
                        state             <= HasShadow ? FlushShadow : FlushIdle;
                    end
                end
                FlushShadow: begin
                    if (shadow_last) begin
                        state <= FlushIdle;
                    end
                end
                default: begin
                    if_redirect_valid <= 1'b0;
                    state             <= FlushIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_branch_flush_ctrl.sv
// Self-checking bench for branch_flush_ctrl: directed scenarios plus randomized
// traffic against a phase-counting reference model.
module tb_branch_flush_ctrl;

    localparam int Shadow = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        b_valid, b_taken, stall, ready;
    logic [31:0] b_target;
    logic        r_valid, ifid, idex, busy;
    logic [31:0] r_pc, tcount;

    logic        z_valid, z_taken, z_stall, z_ready;
    logic [31:0] z_target;
    logic        zr_valid, z_ifid, z_idex, z_busy;
    logic [31:0] zr_pc;
    logic [3:0]  z_count;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: redirect outstanding flag plus remaining shadow cycles.
    bit          m_wait;
    int          m_shadow;
    logic [31:0] m_pc;
    logic [31:0] m_cnt;

    branch_flush_ctrl #(
        .ADDR_W        (32),
        .SHADOW_CYCLES (Shadow),
        .CNT_W         (32)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .ex_branch_valid   (b_valid),
        .ex_branch_taken   (b_taken),
        .ex_branch_target  (b_target),
        .stall_i           (stall),
        .if_redirect_ready (ready),
        .if_redirect_valid (r_valid),
        .if_redirect_pc    (r_pc),
        .IFID_discard_o    (ifid),
        .IDEX_discard_o    (idex),
        .flush_busy        (busy),
        .taken_count       (tcount)
    );

    // Scaled-down counter width stands in for the 2^32 wrap.
    branch_flush_ctrl #(
        .ADDR_W        (32),
        .SHADOW_CYCLES (0),
        .CNT_W         (4)
    ) dut_z (
        .clk               (clk),
        .rst               (rst),
        .ex_branch_valid   (z_valid),
        .ex_branch_taken   (z_taken),
        .ex_branch_target  (z_target),
        .stall_i           (z_stall),
        .if_redirect_ready (z_ready),
        .if_redirect_valid (zr_valid),
        .if_redirect_pc    (zr_pc),
        .IFID_discard_o    (z_ifid),
        .IDEX_discard_o    (z_idex),
        .flush_busy        (z_busy),
        .taken_count       (z_count)
    );

    function automatic bit m_take();
        return (rst === 1'b1) && !m_wait && (m_shadow == 0) && (b_valid === 1'b1)
               && (b_taken === 1'b1) && (stall === 1'b0);
    endfunction

    function automatic bit m_discard();
        return m_wait || (m_shadow > 0) || m_take();
    endfunction

    task automatic model_reset();
        m_wait   = 1'b0;
        m_shadow = 0;
        m_pc     = '0;
        m_cnt    = '0;
    endtask

    task automatic model_edge();
        if (rst !== 1'b1) begin
            model_reset();
        end else if (m_take()) begin
            m_wait = 1'b1;
            m_pc   = {b_target[31:1], 1'b0};
            m_cnt  = m_cnt + 32'd1;
        end else if (m_wait && ready) begin
            m_wait   = 1'b0;
            m_shadow = Shadow;
        end else if (m_shadow > 0) begin
            m_shadow--;
        end
    endtask

    task automatic drive(input logic v, input logic t, input logic [31:0] tgt,
                         input logic s, input logic r);
        b_valid  = v;
        b_taken  = t;
        b_target = tgt;
        stall    = s;
        ready    = r;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        z_valid = 0; z_taken = 0; z_target = '0; z_stall = 0; z_ready = 0;
        drive(1'b1, 1'b1, 32'h0000_1234, 1'b0, 1'b1);
        model_reset();
        #12;
        n_checks++; if (r_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", r_valid); else n_pass++;
        n_checks++; if (r_pc !== 32'h0) $display("FAIL reset_pc: got %h want 0", r_pc); else n_pass++;
        n_checks++; if (tcount !== 32'h0) $display("FAIL reset_count: got %0d want 0", tcount); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if ({ifid, idex} !== 2'b00) $display("FAIL reset_discard: got %b%b want 00", ifid, idex); else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_taken_basic();
        drive(1'b1, 1'b1, 32'h0000_1004, 1'b0, 1'b1);
        @(negedge clk);
        n_checks++; if ({ifid, idex} !== 2'b11) $display("FAIL basic_n_discard: got %b%b want 11", ifid, idex); else n_pass++;
        n_checks++; if ({r_valid, busy} !== 2'b00) $display("FAIL basic_n_idle: got valid=%b busy=%b want 0 0", r_valid, busy); else n_pass++;
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        @(negedge clk);
        n_checks++; if (r_valid !== 1'b1) $display("FAIL basic_n1_valid: got %b want 1", r_valid); else n_pass++;
        n_checks++; if (r_pc !== 32'h0000_1004) $display("FAIL basic_n1_pc: got %h want 00001004", r_pc); else n_pass++;
        n_checks++; if ({ifid, idex} !== 2'b11) $display("FAIL basic_n1_discard: got %b%b want 11", ifid, idex); else n_pass++;
        n_checks++; if (tcount !== 32'd1) $display("FAIL basic_count: got %0d want 1", tcount); else n_pass++;
        tick();
        @(negedge clk);
        n_checks++; if ({busy, r_valid, ifid, idex} !== 4'b1011)
            $display("FAIL basic_shadow: got busy=%b valid=%b disc=%b%b want 1 0 11", busy, r_valid, ifid, idex);
        else n_pass++;
        tick();
        @(negedge clk);
        n_checks++; if ({busy, ifid, idex} !== 3'b000)
            $display("FAIL basic_idle: got busy=%b disc=%b%b want 0 00", busy, ifid, idex);
        else n_pass++;
    endtask

    task automatic test_ready_withheld();
        logic [31:0] tgt;
        logic [31:0] cnt0;
        cnt0 = m_cnt;
        tgt  = $urandom;
        drive(1'b1, 1'b1, tgt, 1'b0, 1'b0);
        @(negedge clk);
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(1'(i % 2), 1'b1, $urandom, 1'b0, 1'b0);
            @(negedge clk);
            n_checks++;
            if (r_valid !== 1'b1 || r_pc !== {tgt[31:1], 1'b0} || {ifid, idex} !== 2'b11
                || tcount !== cnt0 + 32'd1)
                $display("FAIL withheld_%0d: got valid=%b pc=%h disc=%b%b cnt=%0d want 1 %h 11 %0d",
                         i, r_valid, r_pc, ifid, idex, tcount, {tgt[31:1], 1'b0}, cnt0 + 32'd1);
            else n_pass++;
            tick();
        end
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        tick();
        @(negedge clk);
        n_checks++; if ({busy, r_valid, ifid} !== 3'b101)
            $display("FAIL withheld_shadow: got busy=%b valid=%b ifid=%b want 1 0 1", busy, r_valid, ifid);
        else n_pass++;
        tick();
        @(negedge clk);
        n_checks++; if (busy !== 1'b0 || tcount !== cnt0 + 32'd1)
            $display("FAIL withheld_end: got busy=%b cnt=%0d want 0 %0d", busy, tcount, cnt0 + 32'd1);
        else n_pass++;
    endtask

    task automatic test_stalled_jalr();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 32'h0000_2003, 1'b1, 1'b1);
            @(negedge clk);
            n_checks++; if ({ifid, idex, busy} !== 3'b000)
                $display("FAIL stall_%0d: got disc=%b%b busy=%b want 00 0", i, ifid, idex, busy);
            else n_pass++;
            tick();
        end
        drive(1'b1, 1'b1, 32'h0000_2003, 1'b0, 1'b0);
        @(negedge clk);
        n_checks++; if ({ifid, idex} !== 2'b11) $display("FAIL stall_release: got %b%b want 11", ifid, idex); else n_pass++;
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        @(negedge clk);
        n_checks++; if (r_valid !== 1'b1 || r_pc !== 32'h0000_2002)
            $display("FAIL jalr_pc: got valid=%b pc=%h want 1 00002002", r_valid, r_pc);
        else n_pass++;
        for (int i = 0; i < 3; i++) tick();
    endtask

    task automatic test_not_taken();
        logic [31:0] cnt0;
        cnt0 = m_cnt;
        for (int i = 0; i < 11; i++) begin
            drive(1'b1, 1'b0, $urandom, (i == 0) ? 1'b0 : 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)));
            @(negedge clk);
            n_checks++;
            if ({ifid, idex, busy} !== 3'b000 || tcount !== cnt0)
                $display("FAIL not_taken_%0d: got disc=%b%b busy=%b cnt=%0d want 00 0 %0d",
                         i, ifid, idex, busy, tcount, cnt0);
            else n_pass++;
            tick();
        end
    endtask

    task automatic test_random();
        bit ok;
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0), $urandom,
                  1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 2) == 0));
            @(negedge clk);
            ok = (r_valid === m_wait) && (r_pc === m_pc) && (tcount === m_cnt)
                 && (ifid === m_discard()) && (idex === m_discard())
                 && (busy === (m_wait || m_shadow > 0));
            n_checks++;
            if (!ok)
                $display("FAIL random_%0d: got valid=%b pc=%h cnt=%0d disc=%b%b busy=%b want %b %h %0d %b %b",
                         i, r_valid, r_pc, tcount, ifid, idex, busy, m_wait, m_pc, m_cnt,
                         m_discard(), (m_wait || m_shadow > 0));
            else n_pass++;
            tick();
        end
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) tick();
    endtask

    task automatic test_async_reset();
        drive(1'b1, 1'b1, 32'h0000_3000, 1'b0, 1'b0);
        @(negedge clk);
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        n_checks++; if (r_valid !== 1'b1) $display("FAIL arst_pre_valid: got %b want 1", r_valid); else n_pass++;
        #1 rst = 1'b0;
        #1;
        n_checks++; if ({r_valid, busy} !== 2'b00)
            $display("FAIL arst_drop: got valid=%b busy=%b want 0 0", r_valid, busy);
        else n_pass++;
        model_reset();
        tick();
        @(negedge clk);
        rst = 1'b1;
        tick();
        @(negedge clk);
        n_checks++; if (busy !== 1'b0 || tcount !== 32'h0 || r_valid !== 1'b0)
            $display("FAIL arst_after: got busy=%b cnt=%0d valid=%b want 0 0 0", busy, tcount, r_valid);
        else n_pass++;
        tick();
    endtask

    task automatic test_wrap_zero_shadow();
        logic [31:0] tgt;
        for (int i = 0; i < 16; i++) begin
            tgt = $urandom;
            z_valid = 1'b1; z_taken = 1'b1; z_target = tgt; z_stall = 1'b0; z_ready = 1'b1;
            @(negedge clk);
            n_checks++; if ({z_ifid, z_busy} !== 2'b10)
                $display("FAIL wrap_take_%0d: got ifid=%b busy=%b want 1 0", i, z_ifid, z_busy);
            else n_pass++;
            tick();
            z_valid = 1'b0;
            @(negedge clk);
            n_checks++;
            if (zr_valid !== 1'b1 || z_busy !== 1'b1 || zr_pc !== {tgt[31:1], 1'b0}
                || z_count !== 4'((i + 1) % 16))
                $display("FAIL wrap_wait_%0d: got valid=%b busy=%b pc=%h cnt=%0d want 1 1 %h %0d",
                         i, zr_valid, z_busy, zr_pc, z_count, {tgt[31:1], 1'b0}, (i + 1) % 16);
            else n_pass++;
            tick();
            @(negedge clk);
            n_checks++; if ({z_busy, zr_valid, z_ifid, z_idex} !== 4'b0000)
                $display("FAIL wrap_idle_%0d: got busy=%b valid=%b disc=%b%b want 0 0 00",
                         i, z_busy, zr_valid, z_ifid, z_idex);
            else n_pass++;
            tick();
        end
        n_checks++; if (z_count !== 4'h0) $display("FAIL wrap_final: got %0d want 0", z_count); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_taken_basic();
        test_ready_withheld();
        test_stalled_jalr();
        test_not_taken();
        test_random();
        test_async_reset();
        test_wrap_zero_shadow();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
